// File: rtl/jtkicker_rom_arb_if.sv
// jtkicker_rom_arb_if: slot client bus plus SDRAM read port for the ROM arbiter
interface jtkicker_rom_arb_if #(
  parameter int SLOTS    = 4,
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int SDRAM_AW = 22
);
  logic                   downloading;
  logic [SLOTS-1:0]       slot_cs;
  logic [SLOTS*AW-1:0]    slot_addr;
  logic [SLOTS-1:0]       slot_ok;
  logic [SLOTS*DW-1:0]    slot_dout;
  logic                   sdram_req;
  logic [SDRAM_AW-1:0]    sdram_addr;
  logic                   sdram_ack;
  logic                   data_rdy;
  logic [15:0]            data_read;
  modport master (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr
  );
  modport slave (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtkicker_rom_arb.sv
// jtkicker_rom_arb: N-slot ROM client arbiter with one-entry caches onto a single SDRAM read port
module jtkicker_rom_arb #(
  parameter int                        SLOTS    = 4,
  parameter int                        AW       = 15,
  parameter int                        DW       = 16,
  parameter int                        SDRAM_AW = 22,
  parameter logic [SLOTS*SDRAM_AW-1:0] OFFSETS  = '0,
  parameter bit                        RR       = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  jtkicker_rom_arb_if.slave bus
);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                state_q, state_d;
  logic                  req_q, req_d, drop_q, drop_d, found;
  logic [SDRAM_AW-1:0]   addr_q, addr_d, sel_addr;
  logic [SW-1:0]         win_q, win_d, ptr_q, ptr_d, win, idx;
  logic [AW-1:0]         wa_q, wa_d;
  logic [AW-1:0]         waddr [SLOTS];
  logic [AW-1:0]         tag_q [SLOTS];
  logic [AW-1:0]         tag_d [SLOTS];
  logic [15:0]           data_q [SLOTS];
  logic [15:0]           data_d [SLOTS];
  logic [SLOTS-1:0]      valid_q, valid_d, hit, miss;

  genvar k;
  generate
    for (k = 0; k < SLOTS; k++) begin : g_slot
      logic [AW-1:0] a;
      assign a        = bus.slot_addr[k*AW +: AW];
      assign waddr[k] = DW == 8 ? {1'b0, a[AW-1:1]} : a;
      assign hit[k]   = bus.slot_cs[k] & valid_q[k] & (tag_q[k] == waddr[k]);
      if (DW == 8) begin : g_byte
        assign bus.slot_dout[k*DW +: DW] = a[0] ? data_q[k][15:8] : data_q[k][7:0];
      end else begin : g_word
        assign bus.slot_dout[k*DW +: DW] = data_q[k][DW-1:0];
      end
    end
  endgenerate

  assign miss           = bus.slot_cs & ~hit & {SLOTS{~bus.downloading}};
  assign bus.slot_ok    = hit;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;

  always_comb begin
    win      = '0;
    idx      = '0;
    found    = 1'b0;
    sel_addr = '0;
    for (int i = 0; i < SLOTS; i++) begin
      idx = RR ? SW'((int'(ptr_q) + i) % SLOTS) : SW'(i);
      if (!found && miss[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int j = 0; j < SLOTS; j++)
      if (win == SW'(j)) sel_addr = OFFSETS[j*SDRAM_AW +: SDRAM_AW] + SDRAM_AW'(waddr[j]);
  end

  // a download seen at any point during a transaction poisons its fill
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    win_d   = win_q;
    wa_d    = wa_q;
    ptr_d   = ptr_q;
    drop_d  = drop_q | (bus.downloading & (state_q != IDLE));
    valid_d = bus.downloading ? '0 : valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = sel_addr;
        win_d   = win;
        wa_d    = waddr[win];
        drop_d  = 1'b0;
      end
      REQ: if (bus.sdram_ack) begin
        state_d = WAIT;
        req_d   = 1'b0;
      end
      default: if (bus.data_rdy) begin
        state_d        = IDLE;
        tag_d[win_q]   = wa_q;
        data_d[win_q]  = bus.data_read;
        valid_d[win_q] = ~bus.downloading & ~drop_q;
        ptr_d          = (win_q == SW'(SLOTS-1)) ? '0 : win_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      win_q   <= '0;
      wa_q    <= '0;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      wa_q    <= wa_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_jtkicker_rom_arb.sv
// tb_jtkicker_rom_arb: directed checks of word, byte and round-robin arbiter variants
module tb_jtkicker_rom_arb;
  localparam logic [87:0] OFF16 = {22'h3FFFF0, 22'h008000, 22'h004000, 22'h000000};
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cs = '0;
  logic [59:0] addr = '0;
  logic        dl = 1'b0, ack = 1'b0, rdy = 1'b0;
  logic [15:0] rd = '0;
  int          sel = 0;
  int          checks = 0, errors = 0, pulses = 0;
  logic        req_prev = 1'b0;
  logic        req_sel;
  logic [21:0] sa_sel;

  always #5 clk = ~clk;

  jtkicker_rom_arb_if #(.DW(16)) i16 ();
  jtkicker_rom_arb_if #(.DW(8))  i8 ();
  jtkicker_rom_arb_if #(.DW(16)) irr ();

  assign i16.slot_cs = cs; assign i16.slot_addr = addr; assign i16.downloading = dl;
  assign i16.sdram_ack = ack; assign i16.data_rdy = rdy; assign i16.data_read = rd;
  assign i8.slot_cs = cs; assign i8.slot_addr = addr; assign i8.downloading = dl;
  assign i8.sdram_ack = ack; assign i8.data_rdy = rdy; assign i8.data_read = rd;
  assign irr.slot_cs = cs; assign irr.slot_addr = addr; assign irr.downloading = dl;
  assign irr.sdram_ack = ack; assign irr.data_rdy = rdy; assign irr.data_read = rd;

  jtkicker_rom_arb #(.DW(16), .OFFSETS(OFF16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  jtkicker_rom_arb #(.DW(8))                   u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  jtkicker_rom_arb #(.DW(16), .RR(1'b1))       urr (.clk(clk), .rst_n(rst_n), .bus(irr.slave));

  assign req_sel = sel == 0 ? i16.sdram_req  : sel == 1 ? i8.sdram_req  : irr.sdram_req;
  assign sa_sel  = sel == 0 ? i16.sdram_addr : sel == 1 ? i8.sdram_addr : irr.sdram_addr;

  always @(posedge clk) begin
    req_prev <= req_sel;
    if (req_sel && !req_prev) pulses <= pulses + 1;
  end

  typedef struct {
    int          slot;
    logic [14:0] a;
    logic [15:0] d;
    logic [21:0] sa;
  } vec_t;
  vec_t tv [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int s);
    sel = s; rst_n = 1'b0; cs = '0; addr = '0; dl = 1'b0; ack = 1'b0; rdy = 1'b0; rd = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!req_sel && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " req"}, 32'(req_sel), 32'd1);
  endtask

  task automatic serve(input logic [21:0] ea, input logic [15:0] d, input string nm);
    wait_req(nm);
    chk({nm, " addr"}, 32'(sa_sel), 32'(ea));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({nm, " req drop"}, 32'(req_sel), 32'd0);
    tick(); tick();
    rdy = 1'b1; rd = d;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    int p;
    int rnd [4];
    int seq [5];
    tv[0] = '{1, 15'h0012, 16'hBEEF, 22'h004012};
    tv[1] = '{0, 15'h7FFF, 16'h1234, 22'h007FFF};
    tv[2] = '{2, 15'h0100, 16'hCAFE, 22'h008100};
    tv[3] = '{3, 15'h0020, 16'h0F0F, 22'h000010};
    seq   = '{0, 1, 2, 3, 0};

    do_reset(0);
    chk("reset req", 32'(i16.sdram_req), 32'd0);
    chk("reset addr", 32'(i16.sdram_addr), 32'd0);
    chk("reset ok", 32'(i16.slot_ok), 32'd0);
    chk("reset dout", 32'(i16.slot_dout[31:0]), 32'd0);

    for (int i = 0; i < 4; i++) begin
      cs = 4'(1 << tv[i].slot);
      addr[tv[i].slot*15 +: 15] = tv[i].a;
      serve(tv[i].sa, tv[i].d, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d ok", i), 32'(i16.slot_ok), 32'(cs));
      chk($sformatf("vec%0d dout", i), 32'(i16.slot_dout[tv[i].slot*16 +: 16]), 32'(tv[i].d));
      cs = '0;
      #1;
      chk($sformatf("vec%0d ok no cs", i), 32'(i16.slot_ok), 32'd0);
      cs = 4'(1 << tv[i].slot);
      #1;
      chk($sformatf("vec%0d rehit", i), 32'(i16.slot_ok), 32'(cs));
    end
    p = pulses;
    cs = 4'hF;
    tick(); tick(); tick();
    chk("all hit ok", 32'(i16.slot_ok), 32'hF);
    chk("all hit no req", 32'(pulses - p), 32'd0);

    do_reset(1);
    cs = 4'b0001;
    addr[14:0] = 15'h0021;
    serve(22'h000010, 16'hA55A, "byte");
    chk("byte ok", 32'(i8.slot_ok), 32'h1);
    chk("byte hi", 32'(i8.slot_dout[7:0]), 32'hA5);
    addr[14:0] = 15'h0020;
    #1;
    chk("byte lo ok", 32'(i8.slot_ok), 32'h1);
    chk("byte lo", 32'(i8.slot_dout[7:0]), 32'h5A);
    p = pulses;
    tick(); tick(); tick();
    chk("byte no req", 32'(pulses - p), 32'd0);

    do_reset(0);
    p = pulses;
    cs = 4'b0101;
    addr[14:0] = 15'h0050;
    addr[44:30] = 15'h0060;
    serve(22'h000050, 16'h5050, "prio0");
    serve(22'h008060, 16'h6060, "prio2");
    tick(); tick(); tick();
    chk("prio ok", 32'(i16.slot_ok), 32'h5);
    chk("prio pulses", 32'(pulses - p), 32'd2);
    chk("prio dout2", 32'(i16.slot_dout[47:32]), 32'h6060);

    do_reset(2);
    cs = 4'hF;
    for (int s = 0; s < 4; s++) begin
      rnd[s] = 0;
      addr[s*15 +: 15] = 15'(s << 8);
    end
    for (int i = 0; i < 5; i++) begin
      serve(22'((seq[i] << 8) | rnd[seq[i]]), 16'(16'h1000 + i), $sformatf("rr%0d", i));
      chk($sformatf("rr%0d ok", i), 32'(irr.slot_ok[seq[i]]), 32'd1);
      rnd[seq[i]]++;
      addr[seq[i]*15 +: 15] = 15'((seq[i] << 8) | rnd[seq[i]]);
    end

    do_reset(0);
    cs = 4'b0001;
    addr[14:0] = 15'h0100;
    wait_req("chg");
    chk("chg addr", 32'(sa_sel), 32'h100);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    addr[14:0] = 15'h0101;
    tick();
    rdy = 1'b1; rd = 16'h1111;
    tick();
    rdy = 1'b0;
    chk("chg stale ok", 32'(i16.slot_ok), 32'd0);
    serve(22'h000101, 16'h2222, "chg2");
    chk("chg2 ok", 32'(i16.slot_ok), 32'h1);
    chk("chg2 dout", 32'(i16.slot_dout[15:0]), 32'h2222);

    do_reset(0);
    cs = 4'b0011;
    addr[14:0] = 15'h0010;
    addr[29:15] = 15'h0020;
    serve(22'h000010, 16'hAAAA, "dlw0");
    serve(22'h004020, 16'hBBBB, "dlw1");
    chk("dl warm ok", 32'(i16.slot_ok), 32'h3);
    cs = 4'b0111;
    addr[44:30] = 15'h0030;
    wait_req("dl");
    chk("dl addr", 32'(sa_sel), 32'h8030);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dl = 1'b1;
    tick();
    chk("dl ok drop", 32'(i16.slot_ok), 32'd0);
    rdy = 1'b1; rd = 16'hCCCC;
    tick();
    rdy = 1'b0;
    chk("dl fill discarded", 32'(i16.slot_ok), 32'd0);
    p = pulses;
    tick(); tick(); tick(); tick();
    chk("dl no req", 32'(req_sel), 32'd0);
    chk("dl no pulses", 32'(pulses - p), 32'd0);
    dl = 1'b0;
    wait_req("remiss");
    chk("remiss addr", 32'(sa_sel), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst req", 32'(req_sel), 32'd0);
    chk("async rst addr", 32'(sa_sel), 32'd0);
    chk("async rst ok", 32'(i16.slot_ok), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
